btn_debounce_sched: RTL



---
 rtl/btn_sched_pkg.sv | 16 +
 rtl/btn_debounce_sched_sync2.sv | 31 +++
 rtl/btn_debounce_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/btn_sched_pkg.sv
// Shared definitions for the round-robin button debounce scheduler.
package btn_sched_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t SCAN = 1'b1;

  localparam int STABLE_CNT_DEF = 4;

  // Index width for N buttons, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_sched_sync2.sv
// Two-flop synchroniser bringing raw asynchronous inputs into the clk domain.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_debounce_sched.sv
// Debounce scheduler: one counter/compare engine shared round-robin across all
// buttons, one button per clk after each sample tick.
module btn_debounce_sched
  import btn_sched_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int STABLE_CNT = STABLE_CNT_DEF,
  parameter int CW         = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] deb,
  output logic [N_BTN-1:0] rise,
  output logic [N_BTN-1:0] tog,
  output logic             busy,
  output logic             overrun
);

  localparam int IW = idx_w(N_BTN);

  logic [N_BTN-1:0] btn_s;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_BTN-1:0] samp_q, samp_d;
  logic [N_BTN-1:0] deb_q, deb_d;
  logic [N_BTN-1:0] rise_q, rise_d;
  logic [N_BTN-1:0] tog_q, tog_d;
  logic             overrun_q, overrun_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  sync2 #(.W(N_BTN)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn),
    .q    (btn_s)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    samp_d    = samp_q;
    deb_d     = deb_q;
    rise_d    = '0;
    tog_d     = tog_q;
    overrun_d = overrun_q;
    cnt_d     = cnt_q;

    if (state_q == IDLE) begin
      if (en) begin
        samp_d  = btn_s;
        idx_d   = '0;
        state_d = SCAN;
      end
    end else begin
      // A tick landing during a scan, including its last cycle, is dropped.
      if (en) overrun_d = 1'b1;

      if (samp_q[idx_q] == deb_q[idx_q]) begin
        cnt_d[idx_q] = '0;
      end else if (cnt_q[idx_q] == CW'(STABLE_CNT - 1)) begin
        deb_d[idx_q] = samp_q[idx_q];
        cnt_d[idx_q] = '0;
        if (samp_q[idx_q]) begin
          rise_d[idx_q] = 1'b1;
          tog_d[idx_q]  = ~tog_q[idx_q];
        end
      end else begin
        cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
      end

      if (idx_q == IW'(N_BTN - 1)) state_d = IDLE;
      else                         idx_d   = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      samp_q    <= '0;
      deb_q     <= '0;
      rise_q    <= '0;
      tog_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      samp_q    <= samp_d;
      deb_q     <= deb_d;
      rise_q    <= rise_d;
      tog_q     <= tog_d;
      overrun_q <= overrun_d;
      cnt_q     <= cnt_d;
    end
  end

  assign deb     = deb_q;
  assign rise    = rise_q;
  assign tog     = tog_q;
  assign busy    = (state_q == SCAN);
  assign overrun = overrun_q;

endmodule
